// File: rtl/shared_reg_arb_pkg.sv
// Shared-register arbiter: common types and helpers.
// Imported by the picker and the arbiter top.
package shared_reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      COOLDOWN = 2'd2
   } arb_state_t;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req upward from ptr, wrapping past NUM_REQ-1.
module rr_pick
   import shared_reg_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IW-1:0]      pick_idx,
   output logic               any
);

   logic [IW-1:0] idx;

   // Walk from the farthest offset down so the nearest hit wins last.
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      any      = 1'b0;
      idx      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % NUM_REQ);
         if (req[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
            pick_idx  = idx;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one register among requesters.
// Three-state FSM: IDLE samples, GRANT writes, COOLDOWN ignores req.
module shared_reg_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int NUM_REQ   = 4,
   parameter  int CNT_WIDTH = 16,
   localparam int IW        = idx_w(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]           y,
   output logic                       busy,
   output logic [IW-1:0]              owner,
   output logic [CNT_WIDTH-1:0]       wr_count
);

   arb_state_t        state;
   arb_state_t        state_nx;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     win;
   logic [NUM_REQ-1:0] pick;
   logic [IW-1:0]     pick_idx;
   logic              any;
   logic              sample;
   logic              commit;
   logic [WIDTH-1:0]  slot [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      assign slot[i] = wdata[i*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req      (req),
      .ptr      (ptr),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (any) state_nx = GRANT;
         GRANT:    state_nx = COOLDOWN;
         COOLDOWN: state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      sample = (state == IDLE) && any;
      commit = (state == GRANT);
   end

   // The winner is frozen at sampling; later req changes cannot redirect it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt <= '0;
         win <= '0;
      end else if (sample) begin
         gnt <= pick;
         win <= pick_idx;
      end else begin
         gnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y        <= '0;
         owner    <= '0;
         wr_count <= '0;
         ptr      <= '0;
      end else if (commit) begin
         y        <= slot[win];
         owner    <= win;
         wr_count <= wr_count + CNT_WIDTH'(1);
         ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter.
// Driver predicts grants from a queue model; a monitor checks them.
module tb_shared_reg_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]  gnt;
   logic [W-1:0]  y;
   logic          busy;
   logic [IW-1:0] owner;
   logic [CW-1:0] wr_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int w;
      int d;
      int cnt;
      int c;
   } exp_t;

   exp_t sbq[$];

   int ptr_m;
   int cnt_m;
   int free_at;
   bit pend[N];
   int won_at[N];
   bit drop_early[N];

   shared_reg_arbiter #(
      .WIDTH     (W),
      .NUM_REQ   (N),
      .CNT_WIDTH (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .wdata    (wdata),
      .gnt      (gnt),
      .y        (y),
      .busy     (busy),
      .owner    (owner),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ptr_m = 0;
      cnt_m = 0;
      free_at = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         won_at[i] = -10;
         drop_early[i] = 1'b0;
      end
      sbq.delete();
   endtask

   // One cycle of requester behaviour plus the arbitration model.
   task automatic step(input logic [N-1:0] rmask, input logic [N*W-1:0] rdata);
      int s;
      int w;
      logic [IW-1:0] ix;
      @(negedge clk);
      s = cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
         end else if (s == won_at[i] + 1) begin
            if (drop_early[i]) req[i] = 1'b0;
         end else if (s == won_at[i] + 2) begin
            req[i] = 1'b0;
         end else if (rmask[i]) begin
            req[i] = 1'b1;
            wdata[i*W +: W] = rdata[i*W +: W];
            pend[i] = 1'b1;
         end
      end
      if (s >= free_at && req != '0) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            ix = IW'((ptr_m + k) % N);
            if (w < 0 && req[ix]) w = int'(ix);
         end
         cnt_m = (cnt_m + 1) % (1 << CW);
         sbq.push_back('{w, int'(wdata[w*W +: W]), cnt_m, s});
         pend[w] = 1'b0;
         won_at[w] = s;
         drop_early[w] = 1'($urandom_range(0, 1));
         ptr_m = (w + 1) % N;
         free_at = s + 3;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && gnt !== '0) begin
            if (sbq.size() == 0) begin
               chk("gnt_unexpected", 64'(gnt), 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("gnt", 64'(gnt), 64'(1 << e.w));
               chk("gnt_cycle", 64'(cyc), 64'(e.c));
               chk("busy_grant", 64'(busy), 64'd1);
               @(negedge clk);
               chk("y", 64'(y), 64'(e.d));
               chk("owner", 64'(owner), 64'(e.w));
               chk("wr_count", 64'(wr_count), 64'(e.cnt));
               chk("gnt_one_cycle", 64'(gnt), 64'd0);
               chk("busy_cool", 64'(busy), 64'd1);
               @(negedge clk);
               chk("busy_idle", 64'(busy), 64'd0);
            end
         end
      end
   end

   initial begin
      model_reset();
      rst_n = 1'b0;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         req = 4'($urandom);
         wdata = $urandom;
         @(posedge clk);
         #1;
         chk("rst_gnt", 64'(gnt), 64'd0);
         chk("rst_y", 64'(y), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_owner", 64'(owner), 64'd0);
         chk("rst_wr_count", 64'(wr_count), 64'd0);
      end
      @(negedge clk);
      req = '0;
      wdata = '0;
      rst_n = 1'b1;
      model_reset();
      mon_en = 1'b1;

      step(4'hF, 32'h44332211);
      repeat (14) step('0, '0);
      step(4'h1, 32'h000000A5);
      repeat (5) step('0, '0);
      step(4'h4, 32'h00BB0000);
      repeat (4) step('0, '0);
      step(4'h5, 32'h00CC00DD);
      repeat (8) step('0, '0);

      repeat (500) step(4'($urandom & $urandom), $urandom);
      repeat (20) step('0, '0);
      chk("drain_1", 64'(sbq.size()), 64'd0);

      mon_en = 1'b0;
      @(negedge clk);
      req = 4'b0001;
      wdata[7:0] = 8'h5A;
      @(posedge clk);
      #1;
      chk("mid_gnt", 64'(gnt), 64'd1);
      chk("mid_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 64'(gnt), 64'd0);
      chk("mid_rst_y", 64'(y), 64'd0);
      chk("mid_rst_cnt", 64'(wr_count), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      req = '0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_y", 64'(y), 64'd0);
      chk("post_rst_cnt", 64'(wr_count), 64'd0);
      chk("post_rst_owner", 64'(owner), 64'd0);

      model_reset();
      mon_en = 1'b1;
      repeat (200) step(4'($urandom & $urandom), $urandom);
      repeat (20) step('0, '0);
      chk("drain_2", 64'(sbq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
